demux1_to_4_stream: RTL and testbench
=====================================

Name: demux1_to_4_stream

Overview:
Registered 1-to-4 stream demultiplexer with packet locking. It is the distribution-side counterpart of the 4-to-1 selection muxes in the combinational library. One valid/ready input stream is steered to one of four valid/ready output streams by a 2-bit select. The select is locked for the duration of a packet delimited by last. The block sits between a single producer and four consumer lanes.

Parameters:
Width, 32, data bits per beat on input and every output

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
in_data_i  input  Width  input beat data
in_last_i  input  1  marks final beat of packet
in_valid_i  input  1  input beat valid
in_ready_o  output  1  block accepts input beat this cycle
sel_i  input  2  destination select: 0->out1, 1->out2, 2->out3, 3->out4
outN_data_o  output  Width  N=1..4, registered beat data
outN_last_o  output  1  N=1..4, registered last flag
outN_valid_o  output  1  N=1..4, output beat valid
outN_ready_i  input  1  N=1..4, consumer ready
busy_o  output  1  high while in ROUTE state (packet in progress)

Behaviour:
- Reset is asynchronous, active-low, and fixed. On rst_ni=0, all outN_valid_o=0, outN_data_o=0, outN_last_o=0, busy_o=0, FSM=IDLE, locked select=0.
- Transfer rule: a beat transfers on a cycle where valid and ready are both 1, on any port.
- Effective destination d:
  - IDLE: d = sel_i.
  - ROUTE: d = locked select.
- in_ready_o = !outd_valid_o || outd_ready_i. It is combinational from d and the state of lane d, and is independent of the other three lanes.
- Input accept behaviour:
  - An accepted input beat loads lane d's output register with data and last, and sets outd_valid_o=1 on the next edge.
  - Latency is 1 cycle.
  - Full throughput (1 beat/cycle) is sustained while outd_ready_i=1.
- Output hold behaviour:
  - An output beat that transfers with no new load into that lane clears outN_valid_o.
  - Simultaneous drain and load on the same lane: valid stays 1 and data is replaced.
  - Unloaded lanes hold data/last/valid stable while valid=1 and ready=0.
- FSM:
  - IDLE -> ROUTE: on accepted beat with in_last_i=0; locked select <= sel_i.
  - IDLE -> IDLE: on accepted beat with in_last_i=1 (single-beat packet).
  - ROUTE -> IDLE: on accepted beat with in_last_i=1.
  - sel_i is ignored in ROUTE.
- busy_o = (state==ROUTE).
- A stalled lane blocks the input only while it is the current destination. Other lanes drain independently.
- in_valid_i=0 never changes the FSM state.
- Reset mid-packet: all in-flight output beats are discarded, the FSM returns to IDLE, and the next accepted beat uses sel_i.

Optional Feature:
DEMUX_STATS_EN
- Defined: adds ports cntN_o (output, 16 bits, N=1..4).
  - Each is a beat counter incremented on every output transfer of lane N (outN_valid_o && outN_ready_i).
  - Counters wrap 0xFFFF->0x0000 and reset to 0.
- Not defined: the ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset then single beats: sel_i=2, data=0xA5A5A5A5, last=1, all readys=1 -> out3_valid_o=1 with data 0xA5A5A5A5 one cycle later; other valids 0; busy_o stays 0.
- Packet lock: 4-beat packet 0x10..0x13 starting with sel_i=1; sel_i toggled to 3 on beats 2-4 -> all four beats appear on out2 in order, out2_last_o=1 on 0x13 only; busy_o high from after beat 1 until after beat 4.
- Backpressure: out1_ready_i=0, send 2 beats to lane 0 -> first beat held stable, in_ready_o=0 for second. Raise out1_ready_i -> second accepted the same cycle (drain and load), no beat lost.
- Independent lanes: out4_ready_i=0 with out4 full; beat with sel_i=0 -> in_ready_o=1, beat routed to out1 while out4 holds its value.
- Reset mid-packet: assert rst_ni=0 during beat 2 of a 3-beat packet to lane 2 -> all valids 0 immediately (async), busy_o=0. After release, beat with sel_i=0 goes to out1.
- Stats (DEMUX_STATS_EN): 5 transfers to lane 3 and 2 to lane 1 -> cnt4_o=5, cnt2_o=2, others 0. Preload wrap via 65537 transfers on lane 1 -> cnt1_o=1.

Source files
------------

// File: rtl/demux1_to_4_stream_if.sv
// Stream bundle for demux1_to_4_stream: one producer-facing input stream, four
// consumer lanes, the busy flag and, when DEMUX_STATS_EN is defined, lane counters.
interface demux1_to_4_stream_if #(
    parameter int Width = 32
);
    logic [Width-1:0] in_data_i;
    logic             in_last_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [1:0]       sel_i;

    logic [Width-1:0] out1_data_o;
    logic             out1_last_o;
    logic             out1_valid_o;
    logic             out1_ready_i;
    logic [Width-1:0] out2_data_o;
    logic             out2_last_o;
    logic             out2_valid_o;
    logic             out2_ready_i;
    logic [Width-1:0] out3_data_o;
    logic             out3_last_o;
    logic             out3_valid_o;
    logic             out3_ready_i;
    logic [Width-1:0] out4_data_o;
    logic             out4_last_o;
    logic             out4_valid_o;
    logic             out4_ready_i;

    logic             busy_o;

`ifdef DEMUX_STATS_EN
    logic [15:0]      cnt1_o;
    logic [15:0]      cnt2_o;
    logic [15:0]      cnt3_o;
    logic [15:0]      cnt4_o;
`endif

    // Environment side: drives the input stream and the consumer readys
    modport master (
        output in_data_i, in_last_i, in_valid_i, sel_i,
        output out1_ready_i, out2_ready_i, out3_ready_i, out4_ready_i,
        input  in_ready_o, busy_o,
        input  out1_data_o, out1_last_o, out1_valid_o,
        input  out2_data_o, out2_last_o, out2_valid_o,
        input  out3_data_o, out3_last_o, out3_valid_o,
        input  out4_data_o, out4_last_o, out4_valid_o
`ifdef DEMUX_STATS_EN
        , input cnt1_o, cnt2_o, cnt3_o, cnt4_o
`endif
    );

    modport slave (
        input  in_data_i, in_last_i, in_valid_i, sel_i,
        input  out1_ready_i, out2_ready_i, out3_ready_i, out4_ready_i,
        output in_ready_o, busy_o,
        output out1_data_o, out1_last_o, out1_valid_o,
        output out2_data_o, out2_last_o, out2_valid_o,
        output out3_data_o, out3_last_o, out3_valid_o,
        output out4_data_o, out4_last_o, out4_valid_o
`ifdef DEMUX_STATS_EN
        , output cnt1_o, cnt2_o, cnt3_o, cnt4_o
`endif
    );
endinterface

// File: rtl/demux1_to_4_stream.sv
// Registered 1-to-4 valid/ready stream demux; the select is locked for a whole packet.
// Optional per-lane beat counters are enabled with `define DEMUX_STATS_EN.
module demux1_to_4_stream #(
    parameter int Width = 32
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    demux1_to_4_stream_if.slave  bus
);
    typedef enum logic {IDLE, ROUTE} state_t;

    state_t           state, state_next;
    logic [1:0]       lock_sel, lock_next;
    logic [1:0]       dest;
    logic             in_ready;
    logic             accept;
    logic [Width-1:0] lane_data [4];
    logic [3:0]       lane_last;
    logic [3:0]       lane_valid;
    logic [3:0]       lane_ready;

    assign lane_ready = {bus.out4_ready_i, bus.out3_ready_i, bus.out2_ready_i, bus.out1_ready_i};

    // Input readiness looks only at the current destination lane, so a stalled
    // lane elsewhere never blocks traffic headed somewhere else
    assign dest     = (state == ROUTE) ? lock_sel : bus.sel_i;
    assign in_ready = !lane_valid[dest] || lane_ready[dest];
    assign accept   = bus.in_valid_i && in_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            lock_sel <= 2'd0;
        end else begin
            state    <= state_next;
            lock_sel <= lock_next;
        end
    end

    always_comb begin
        state_next = state;
        lock_next  = lock_sel;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!bus.in_last_i) begin
                        state_next = ROUTE;
                        lock_next  = bus.sel_i;
                    end
                end
                ROUTE: begin
                    if (bus.in_last_i) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A load wins over a drain, which keeps valid high and replaces the beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                lane_data[i] <= '0;
            end
            lane_last  <= '0;
            lane_valid <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && dest == 2'(i)) begin
                    lane_data[i]  <= bus.in_data_i;
                    lane_last[i]  <= bus.in_last_i;
                    lane_valid[i] <= 1'b1;
                end else if (lane_valid[i] && lane_ready[i]) begin
                    lane_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.busy_o       = (state == ROUTE);
    assign bus.out1_data_o  = lane_data[0];
    assign bus.out2_data_o  = lane_data[1];
    assign bus.out3_data_o  = lane_data[2];
    assign bus.out4_data_o  = lane_data[3];
    assign bus.out1_last_o  = lane_last[0];
    assign bus.out2_last_o  = lane_last[1];
    assign bus.out3_last_o  = lane_last[2];
    assign bus.out4_last_o  = lane_last[3];
    assign bus.out1_valid_o = lane_valid[0];
    assign bus.out2_valid_o = lane_valid[1];
    assign bus.out3_valid_o = lane_valid[2];
    assign bus.out4_valid_o = lane_valid[3];

`ifdef DEMUX_STATS_EN
    logic [15:0] lane_cnt [4];

    // Counts completed output transfers; wraps naturally at 16 bits
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                lane_cnt[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lane_valid[i] && lane_ready[i]) begin
                    lane_cnt[i] <= lane_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign bus.cnt1_o = lane_cnt[0];
    assign bus.cnt2_o = lane_cnt[1];
    assign bus.cnt3_o = lane_cnt[2];
    assign bus.cnt4_o = lane_cnt[3];
`endif
endmodule

// File: tb/tb_demux1_to_4_stream.sv
// Self-checking bench for demux1_to_4_stream: directed scenarios plus random traffic
// checked against a per-lane queue model; covers counters when DEMUX_STATS_EN is defined.
module tb_demux1_to_4_stream;
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk_i;
    logic        rst_ni;
    logic        stim_valid;
    logic [1:0]  stim_sel;
    logic [31:0] stim_data;
    logic        stim_last;
    logic [3:0]  stim_rdy;

    int checks = 0;
    int errors = 0;

    // Model: beats accepted into each lane and not yet taken by its consumer
    beat_t       pending [4][$];
    logic        packet_open;
    logic [1:0]  packet_dest;
    int          model_cnt [4];

    logic [3:0]  obs_valid;
    logic [3:0]  obs_last;
    logic [31:0] obs_data [4];
    logic [15:0] obs_cnt [4];

    demux1_to_4_stream_if #(.Width(32)) bus ();

    demux1_to_4_stream #(.Width(32)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    assign bus.in_valid_i   = stim_valid;
    assign bus.sel_i        = stim_sel;
    assign bus.in_data_i    = stim_data;
    assign bus.in_last_i    = stim_last;
    assign bus.out1_ready_i = stim_rdy[0];
    assign bus.out2_ready_i = stim_rdy[1];
    assign bus.out3_ready_i = stim_rdy[2];
    assign bus.out4_ready_i = stim_rdy[3];

    assign obs_valid   = {bus.out4_valid_o, bus.out3_valid_o, bus.out2_valid_o, bus.out1_valid_o};
    assign obs_last    = {bus.out4_last_o, bus.out3_last_o, bus.out2_last_o, bus.out1_last_o};
    assign obs_data[0] = bus.out1_data_o;
    assign obs_data[1] = bus.out2_data_o;
    assign obs_data[2] = bus.out3_data_o;
    assign obs_data[3] = bus.out4_data_o;
`ifdef DEMUX_STATS_EN
    assign obs_cnt[0] = bus.cnt1_o;
    assign obs_cnt[1] = bus.cnt2_o;
    assign obs_cnt[2] = bus.cnt3_o;
    assign obs_cnt[3] = bus.cnt4_o;
`else
    assign obs_cnt[0] = 16'd0;
    assign obs_cnt[1] = 16'd0;
    assign obs_cnt[2] = 16'd0;
    assign obs_cnt[3] = 16'd0;
`endif

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_dest();
        return packet_open ? packet_dest : stim_sel;
    endfunction

    function automatic logic model_ready();
        logic [1:0] d;
        d = model_dest();
        return (pending[d].size() == 0) || stim_rdy[d];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            pending[i].delete();
            model_cnt[i] = 0;
        end
        packet_open = 1'b0;
        packet_dest = 2'd0;
    endtask

    task automatic apply_stimulus(input logic v, input logic [1:0] s, input logic [31:0] dt,
                                  input logic lst, input logic [3:0] rdy);
        stim_valid = v;
        stim_sel   = s;
        stim_data  = dt;
        stim_last  = lst;
        stim_rdy   = rdy;
        #1;
    endtask

    task automatic check_output();
        check_val("in_ready", bus.in_ready_o, model_ready());
        check_val("busy", bus.busy_o, packet_open);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("out%0d_valid", i + 1), obs_valid[i], pending[i].size() != 0);
            if (pending[i].size() != 0) begin
                check_val($sformatf("out%0d_data", i + 1), obs_data[i], pending[i][0].data);
                check_val($sformatf("out%0d_last", i + 1), obs_last[i], pending[i][0].last);
            end
`ifdef DEMUX_STATS_EN
            check_val($sformatf("cnt%0d", i + 1), obs_cnt[i], model_cnt[i] % 65536);
`endif
        end
    endtask

    task automatic check_reset_values();
        check_val("rst_busy", bus.busy_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("rst_out%0d_valid", i + 1), obs_valid[i], 1'b0);
            check_val($sformatf("rst_out%0d_data", i + 1), obs_data[i], 32'd0);
            check_val($sformatf("rst_out%0d_last", i + 1), obs_last[i], 1'b0);
`ifdef DEMUX_STATS_EN
            check_val($sformatf("rst_cnt%0d", i + 1), obs_cnt[i], 32'd0);
`endif
        end
    endtask

    // Check at the current point, then advance one clock and update the model
    task automatic run_cycle();
        logic [1:0] d;
        logic       acc;
        logic [3:0] drn;
        check_output();
        d   = model_dest();
        acc = stim_valid && model_ready();
        for (int i = 0; i < 4; i++) begin
            drn[i] = (pending[i].size() != 0) && stim_rdy[i];
        end
        @(posedge clk_i);
        for (int i = 0; i < 4; i++) begin
            if (drn[i]) begin
                void'(pending[i].pop_front());
                model_cnt[i]++;
            end
        end
        if (acc) begin
            pending[d].push_back('{data: stim_data, last: stim_last});
            if (!packet_open && !stim_last) begin
                packet_open = 1'b1;
                packet_dest = stim_sel;
            end else if (packet_open && stim_last) begin
                packet_open = 1'b0;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'b0000);
        do_reset();

        // Single beat to lane index 2
        apply_stimulus(1'b1, 2'd2, 32'hA5A5_A5A5, 1'b1, 4'b1111);
        run_cycle();
        apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'b1111);
        check_val("single_out3_valid", bus.out3_valid_o, 1'b1);
        check_val("single_out3_data", bus.out3_data_o, 32'hA5A5_A5A5);
        run_cycle();

        // Packet lock: select changes after the first beat are ignored
        for (int b = 0; b < 4; b++) begin
            apply_stimulus(1'b1, (b == 0) ? 2'd1 : 2'd3, 32'h10 + 32'(b), b == 3, 4'b1111);
            run_cycle();
            check_val("lock_busy", bus.busy_o, b != 3);
            check_val("lock_out2_data", bus.out2_data_o, 32'h10 + 32'(b));
        end
        apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'b1111);
        run_cycle();

        // Backpressure on lane index 0, then drain-and-load in one cycle
        apply_stimulus(1'b1, 2'd0, 32'h20, 1'b1, 4'b1110);
        run_cycle();
        apply_stimulus(1'b1, 2'd0, 32'h21, 1'b1, 4'b1110);
        check_val("bp_in_ready_low", bus.in_ready_o, 1'b0);
        run_cycle();
        run_cycle();
        apply_stimulus(1'b1, 2'd0, 32'h21, 1'b1, 4'b1111);
        check_val("bp_in_ready_high", bus.in_ready_o, 1'b1);
        run_cycle();
        check_val("bp_second_beat", bus.out1_data_o, 32'h21);
        apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'b1111);
        run_cycle();

        // Stalled lane index 3 does not block traffic to lane index 0
        apply_stimulus(1'b1, 2'd3, 32'h30, 1'b1, 4'b0111);
        run_cycle();
        apply_stimulus(1'b1, 2'd0, 32'h31, 1'b1, 4'b0111);
        check_val("indep_in_ready", bus.in_ready_o, 1'b1);
        run_cycle();
        check_val("indep_out4_hold", bus.out4_data_o, 32'h30);
        apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'b1111);
        run_cycle();
        run_cycle();

        // Asynchronous reset in the middle of a packet
        apply_stimulus(1'b1, 2'd2, 32'h40, 1'b0, 4'b1111);
        run_cycle();
        apply_stimulus(1'b1, 2'd2, 32'h41, 1'b0, 4'b1111);
        #1;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply_stimulus(1'b1, 2'd0, 32'h50, 1'b1, 4'b1111);
        run_cycle();
        check_val("post_rst_out1", bus.out1_valid_o, 1'b1);
        check_val("post_rst_out3", bus.out3_valid_o, 1'b0);
        apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'b1111);
        run_cycle();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                           $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
            run_cycle();
        end
        for (int n = 0; n < 3; n++) begin
            apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'b1111);
            run_cycle();
        end

`ifdef DEMUX_STATS_EN
        do_reset();
        for (int n = 0; n < 7; n++) begin
            apply_stimulus(1'b1, (n < 5) ? 2'd3 : 2'd1, 32'h60 + 32'(n), 1'b1, 4'b1111);
            run_cycle();
        end
        apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'b1111);
        run_cycle();
        check_val("stats_cnt1", bus.cnt1_o, 32'd0);
        check_val("stats_cnt2", bus.cnt2_o, 32'd2);
        check_val("stats_cnt3", bus.cnt3_o, 32'd0);
        check_val("stats_cnt4", bus.cnt4_o, 32'd5);
        for (int n = 0; n < 65537; n++) begin
            apply_stimulus(1'b1, 2'd0, 32'(n), 1'b1, 4'b1111);
            run_cycle();
        end
        apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0, 4'b1111);
        run_cycle();
        check_val("stats_wrap_cnt1", bus.cnt1_o, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
